// File: rtl/apb_fnd_scan_ctrl.sv
// APB slave driving a multiplexed seven-segment display; decimal digits come from a
// sequential double-dabble engine. Optional blink feature compiled in by `define FND_BLINK_EN.
module apb_fnd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 14,
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_DIV  = 500
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [3:0]            PADDR,
  input  logic                  PWRITE,
  input  logic                  PENABLE,
  input  logic [31:0]           PWDATA,
  input  logic                  PSEL,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic [NUM_DIGITS-1:0] fndCom,
  output logic [7:0]            fndFont
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int EXT_W = (BCD_W > DATA_W) ? BCD_W : DATA_W;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t state, next_state;

  logic                  wr_access, rd_access, trigger, busy, blank;
  logic [1:0]            reg_sel;
  logic                  fcr_en, fcr_hex;
  logic [DATA_W-1:0]     fdr;
  logic [NUM_DIGITS-1:0] fpr;
  logic [DATA_W-1:0]     bin_sr;
  logic [BCD_W-1:0]      bcd_sr, bcd_adj, hex_digits, digit_buf;
  logic [EXT_W-1:0]      bin_ext;
  logic                  mode_hex;
  logic [CNT_W-1:0]      bit_cnt;
  logic [PRE_W-1:0]      presc;
  logic [IDX_W-1:0]      idx;
  logic                  period_end;
  logic [3:0]            digit;
  logic                  unused_bits;

  assign wr_access = PSEL & PENABLE & PWRITE;
  assign rd_access = PSEL & PENABLE & ~PWRITE;
  assign reg_sel   = PADDR[3:2];
  assign PREADY    = PSEL & PENABLE;
  assign busy      = (state != IDLE);
  assign trigger   = wr_access & ((reg_sel == 2'd1) |
                                  ((reg_sel == 2'd0) & (PWDATA[1] != fcr_hex)));

`ifdef FND_BLINK_EN
  logic fcr_blink;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      fcr_en  <= 1'b0;
      fcr_hex <= 1'b0;
`ifdef FND_BLINK_EN
      fcr_blink <= 1'b0;
`endif
      fdr <= '0;
      fpr <= '0;
    end else if (wr_access) begin
      case (reg_sel)
        2'd0: begin
          fcr_en  <= PWDATA[0];
          fcr_hex <= PWDATA[1];
`ifdef FND_BLINK_EN
          fcr_blink <= PWDATA[2];
`endif
        end
        2'd1:    fdr <= PWDATA[DATA_W-1:0];
        2'd2:    fpr <= PWDATA[NUM_DIGITS-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= next_state;
  end

  // A fresh trigger always wins, aborting any conversion in flight.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  next_state = IDLE;
      LOAD:  next_state = fcr_hex ? DONE : SHIFT;
      SHIFT: if (bit_cnt == CNT_W'(DATA_W - 1)) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (trigger) next_state = LOAD;
  end

  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  assign bin_ext    = EXT_W'(bin_sr);
  assign hex_digits = bin_ext[BCD_W-1:0];

  // Only NUM_DIGITS BCD digits are kept; carries out of the top digit are the 10^N overflow.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      bin_sr    <= '0;
      bcd_sr    <= '0;
      mode_hex  <= 1'b0;
      bit_cnt   <= '0;
      digit_buf <= '0;
    end else begin
      case (state)
        LOAD: begin
          bin_sr   <= fdr;
          bcd_sr   <= '0;
          mode_hex <= fcr_hex;
          bit_cnt  <= '0;
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
          bit_cnt          <= bit_cnt + 1'b1;
        end
        DONE:    digit_buf <= mode_hex ? hex_digits : bcd_sr;
        default: ;
      endcase
    end
  end

  assign period_end = (presc == PRE_W'(SCAN_DIV - 1)) && (idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

`ifdef FND_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  // Phase 0 is the blank half, so the display goes dark first after BLINK is set.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!fcr_blink) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (period_end) begin
      if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blank = fcr_blink & ~blink_phase;
`else
  localparam int unused_blink_div = BLINK_DIV;
  assign blank = 1'b0;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  assign digit = digit_buf[{idx, 2'b00} +: 4];

  always_comb begin
    fndCom  = '1;
    fndFont = 8'hFF;
    if (fcr_en && !blank) begin
      fndCom[idx] = 1'b0;
      fndFont     = ~{fpr[idx], seg7(digit)};
    end
  end

  always_comb begin
    PRDATA = '0;
    if (rd_access) begin
      case (reg_sel)
        2'd0: begin
          PRDATA[0] = fcr_en;
          PRDATA[1] = fcr_hex;
`ifdef FND_BLINK_EN
          PRDATA[2] = fcr_blink;
`endif
        end
        2'd1:    PRDATA[DATA_W-1:0]     = fdr;
        2'd2:    PRDATA[NUM_DIGITS-1:0] = fpr;
        default: PRDATA[0]              = busy;
      endcase
    end
  end

  assign unused_bits = ^{PWDATA, PADDR[1:0], bin_ext};

endmodule
